// File: rtl/mmm_sequencer.sv
// rtl/mmm_sequencer.sv - operand-side sequencer for the word-serial Montgomery kernel
//
// Accepts one (X, Y, M) job, runs dw kernel iterations feeding one X bit per
// iteration (LSB first), carries the partial sum S between iterations and
// finishes with a conditional subtraction to present X*Y*2^-dw mod M.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        job handshake, operands X, Y, M (dw bits)
//   res/res_valid/res_ready  result handshake
//   busy                     job in flight, accept until result handshake
//   err                      sticky kernel-timeout flag
//   k_clr, k_en, k_xi        kernel clear, enable and current X bit
//   k_Y, k_M                 latched operands to the kernel
//   k_S0, k_S1, k_S2         partial-sum words, S = {S2,S1,S0}
//   k_S_new, k_done          kernel result and its valid strobe

module mmm_sequencer #(
    parameter int dw  = 6,
    parameter int w   = 3,
    parameter int tmo = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [dw-1:0]   X,
    input  logic [dw-1:0]   Y,
    input  logic [dw-1:0]   M,
    output logic [dw-1:0]   res,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            err,
    output logic            k_clr,
    output logic            k_en,
    output logic            k_xi,
    output logic [dw-1:0]   k_Y,
    output logic [dw-1:0]   k_M,
    output logic [w-1:0]    k_S0,
    output logic [w-1:0]    k_S1,
    output logic [w-1:0]    k_S2,
    input  logic [3*w-1:0]  k_S_new,
    input  logic            k_done
);

    localparam int IW = $clog2(dw + 1);
    localparam int WW = $clog2(tmo + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_FINAL,
        ST_OUT
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [dw-1:0]  r_x, w_x_nxt;           // remaining X bits, shifted right per iteration
    logic [dw:0]    r_s, w_s_nxt;           // partial sum, always < 2M so dw+1 bits suffice
    logic [IW-1:0]  r_i, w_i_nxt;
    logic [WW-1:0]  r_wdog, w_wdog_nxt;
    logic           r_in_ready, w_in_ready_nxt;
    logic [dw-1:0]  r_res, w_res_nxt;
    logic           r_res_valid, w_res_valid_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_err, w_err_nxt;
    logic           r_k_clr, w_k_clr_nxt;
    logic           r_k_en, w_k_en_nxt;
    logic           r_k_xi, w_k_xi_nxt;
    logic [dw-1:0]  r_k_y, w_k_y_nxt;
    logic [dw-1:0]  r_k_m, w_k_m_nxt;
    logic [3*w-1:0] r_k_s, w_k_s_nxt;

    logic           w_ge;
    logic [dw:0]    w_diff;
    logic           w_unused;

    assign w_ge     = (r_s >= {1'b0, r_k_m});
    assign w_diff   = r_s - {1'b0, r_k_m};
    // Upper kernel-result bits are zero by construction and deliberately dropped.
    assign w_unused = ^(k_S_new >> (dw + 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_s_nxt         = r_s;
        w_i_nxt         = r_i;
        w_wdog_nxt      = r_wdog;
        w_in_ready_nxt  = r_in_ready;
        w_res_nxt       = r_res;
        w_res_valid_nxt = r_res_valid;
        w_busy_nxt      = r_busy;
        w_err_nxt       = r_err;
        w_k_clr_nxt     = r_k_clr;
        w_k_en_nxt      = r_k_en;
        w_k_xi_nxt      = r_k_xi;
        w_k_y_nxt       = r_k_y;
        w_k_m_nxt       = r_k_m;
        w_k_s_nxt       = r_k_s;

        // Outputs are registered, so each transition loads the values the
        // destination state must present during its first cycle.
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_x_nxt        = X;
                    w_k_y_nxt      = Y;
                    w_k_m_nxt      = M;
                    w_s_nxt        = '0;
                    w_i_nxt        = '0;
                    w_err_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_in_ready_nxt = 1'b0;
                    w_k_clr_nxt    = 1'b1;
                    w_k_xi_nxt     = X[0];
                    w_k_s_nxt      = '0;
                    w_state_nxt    = ST_CLR;
                end
            end
            ST_CLR: begin
                w_k_clr_nxt = 1'b0;
                w_k_en_nxt  = 1'b1;
                w_wdog_nxt  = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (k_done) begin
                    w_s_nxt    = k_S_new[dw:0];
                    w_i_nxt    = r_i + IW'(1);
                    w_x_nxt    = r_x >> 1;
                    w_k_en_nxt = 1'b0;
                    if (r_i == IW'(dw - 1)) begin
                        w_state_nxt = ST_FINAL;
                    end else begin
                        w_k_clr_nxt = 1'b1;
                        w_k_xi_nxt  = r_x[1];
                        w_k_s_nxt   = (3*w)'(k_S_new[dw:0]);
                        w_state_nxt = ST_CLR;
                    end
                end else if (r_wdog == WW'(tmo - 1)) begin
                    // tmo-th RUN cycle without k_done: abandon the job with a zero result.
                    w_err_nxt       = 1'b1;
                    w_res_nxt       = '0;
                    w_k_en_nxt      = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = ST_OUT;
                end else begin
                    w_wdog_nxt = r_wdog + WW'(1);
                end
            end
            ST_FINAL: begin
                w_res_nxt       = w_ge ? w_diff[dw-1:0] : r_s[dw-1:0];
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_s         <= '0;
            r_i         <= '0;
            r_wdog      <= '0;
            r_in_ready  <= 1'b1;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_k_clr     <= 1'b0;
            r_k_en      <= 1'b0;
            r_k_xi      <= 1'b0;
            r_k_y       <= '0;
            r_k_m       <= '0;
            r_k_s       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_s         <= w_s_nxt;
            r_i         <= w_i_nxt;
            r_wdog      <= w_wdog_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_res       <= w_res_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_k_clr     <= w_k_clr_nxt;
            r_k_en      <= w_k_en_nxt;
            r_k_xi      <= w_k_xi_nxt;
            r_k_y       <= w_k_y_nxt;
            r_k_m       <= w_k_m_nxt;
            r_k_s       <= w_k_s_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign err       = r_err;
    assign k_clr     = r_k_clr;
    assign k_en      = r_k_en;
    assign k_xi      = r_k_xi;
    assign k_Y       = r_k_y;
    assign k_M       = r_k_m;
    assign k_S0      = r_k_s[w-1:0];
    assign k_S1      = r_k_s[2*w-1:w];
    assign k_S2      = r_k_s[3*w-1:2*w];

endmodule
